// File: rtl/count_pkg.sv
// count_pkg
// Shared constants for the counter control stage: default widths and timing
// values, plus the encoding of the counter direction line.
package count_pkg;

  // Default width of the switch bank and of the load value sent to the counter
  localparam int CNT_W_DEF = 4;

  // Default prescaler period (clk cycles between En pulses while running)
  localparam int DIV_DEF = 5;

  // Default number of cycles a synchronised button level must stay stable
  localparam int DB_CYCLES_DEF = 4;

  // Encoding of the up_down line seen by the counter
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Synchronises one raw push-button and accepts a new level only after it has
// been seen unchanged for DB_CYCLES consecutive cycles. Emits a one-cycle
// pulse on every accepted rising level; accepted releases give no pulse.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous, active-high reset (clears all internal state)
//   raw    - asynchronous button level
//   stable - debounced button level
//   press  - one-cycle pulse when stable rises
module btn_debounce
  import count_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic            s1;
  logic            s2;
  logic            stable_d;
  logic [DB_W-1:0] cnt;

  // The counter measures how long s2 has disagreed with the accepted level;
  // any agreement restarts the qualification, so short glitches are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_d <= stable;
      if (s2 != stable) begin
        if (cnt == DB_W'(DB_CYCLES - 1)) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = stable & ~stable_d;

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl
// Turns three raw push-buttons and a switch bank into the control inputs of
// the 4-bit up/down counter: load value, load strobe, prescaled count enable
// and direction. Also reports the run state for a status LED.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous, active-high reset
//   btn_load - raw load button
//   btn_dir  - raw direction-toggle button
//   btn_run  - raw run/stop-toggle button
//   sw_R     - raw load-value switches
//   R        - registered load value
//   L        - registered load strobe, one cycle per accepted press
//   En       - registered count enable, one-cycle pulse per prescaler tick
//   up_down  - registered direction (1 = up, 0 = down)
//   run      - registered run state
module count_ctrl
  import count_pkg::*;
#(
  parameter int DIV       = DIV_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_load,
  input  logic             btn_dir,
  input  logic             btn_run,
  input  logic [CNT_W-1:0] sw_R,
  output logic [CNT_W-1:0] R,
  output logic             L,
  output logic             En,
  output logic             up_down,
  output logic             run
);

  localparam int PRESC_W = $clog2(DIV);

  logic               press_load;
  logic               press_dir;
  logic               press_run;
  logic [2:0]         db_stable_unused;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_next;
  logic               run_next;
  logic               tick;

  // The debounced levels are not needed here, only the press pulses.
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
    .clk    (clk),
    .rst    (rst),
    .raw    (btn_load),
    .stable (db_stable_unused[0]),
    .press  (press_load)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
    .clk    (clk),
    .rst    (rst),
    .raw    (btn_dir),
    .stable (db_stable_unused[1]),
    .press  (press_dir)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .clk    (clk),
    .rst    (rst),
    .raw    (btn_run),
    .stable (db_stable_unused[2]),
    .press  (press_run)
  );

  assign run_next = run ^ press_run;
  assign tick     = (presc == PRESC_W'(DIV - 1)) & run;

  // The prescaler is forced to zero both while stopped and on the cycle that
  // stops it, so it never shows a stale count while run is low. Starting from
  // zero on the cycle run rises places the first En exactly DIV cycles later.
  // A load restarts the period so the counter gets a full interval after it.
  always_comb begin
    presc_next = presc + PRESC_W'(1);
    if (press_load || !run || !run_next || tick) begin
      presc_next = '0;
    end
  end

  // Output registers. En is masked by press_load so the counter never sees a
  // load and a count in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      R       <= '0;
      L       <= 1'b0;
      En      <= 1'b0;
      up_down <= DIR_UP;
      run     <= 1'b0;
      presc   <= '0;
    end else begin
      L     <= press_load;
      En    <= tick & ~press_load;
      run   <= run_next;
      presc <= presc_next;
      if (press_load) begin
        R <= sw_R;
      end
      if (press_dir) begin
        up_down <= ~up_down;
      end
    end
  end

endmodule

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
Control-generation stage that sits directly upstream of the 4-bit up/down counter. It converts three raw push-buttons and a 4-bit switch bank into the counter's control inputs: load value R, one-cycle load strobe L, count enable En and direction up_down. It contains the button debouncing, the edge detection, the run/direction toggles and a prescaler, so the counter advances at a visible rate.

Parameters:
DIV, 5, prescaler period in clk cycles between En pulses while running (DIV >= 2)
DB_CYCLES, 4, cycles a synchronised button level must stay stable before it is accepted (>= 2)
CNT_W, 4, width of switch input and R output

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
btn_load  input  1  raw load button, asynchronous, active-high
btn_dir  input  1  raw direction-toggle button
btn_run  input  1  raw run/stop-toggle button
sw_R  input  CNT_W  raw load-value switches
R  output  CNT_W  registered load value to counter
L  output  1  registered load strobe, exactly one cycle per accepted press
En  output  1  registered count enable, one-cycle pulse per prescaler tick
up_down  output  1  registered direction: 1 = up, 0 = down
run  output  1  registered run state, for status LED

Behaviour:
- Reset is synchronous and active-high. At the first rising edge with rst=1: R=0, L=0, En=0, up_down=1, run=0, prescaler=0, all debouncer sync/stable/counter state is 0. rst has priority over every other event.
- Debounce per button:
  - 2-FF synchroniser s1 -> s2.
  - If s2 != stable: when cnt == DB_CYCLES-1, set stable <= s2 and cnt <= 0; otherwise cnt++.
  - If s2 == stable: cnt <= 0.
  - press = stable & ~stable_d, a one-cycle pulse on each accepted rising level only.
  - A raw level held for fewer than DB_CYCLES cycles after synchronisation is discarded.
  - Release is filtered the same way and produces no pulse.
- Latency: the edge at which raw high is first sampled counts as edge 1. Stable goes high at edge DB_CYCLES+2. The registered output reaction (L, R, run, up_down) is visible after edge DB_CYCLES+3.
- Load:
  - On press_load: L <= 1 for exactly one cycle and R <= sw_R, captured in the same cycle as press_load.
  - R holds between loads.
  - The prescaler clears to 0 in the same cycle.
- Run:
  - Each press_run toggles run.
  - When run=0, the prescaler is held at 0.
- Direction:
  - Each press_dir toggles up_down.
  - Holding the button yields one toggle only.
- Prescaler:
  - While run=1, counts 0..DIV-1 and wraps to 0.
  - tick = (presc == DIV-1) & run.
  - En <= tick & ~press_load, so En and L are never high in the same cycle.
  - After run is set, the first En is asserted DIV cycles later and then every DIV cycles.
- Simultaneous events:
  - run and dir presses in the same cycle are both applied.
  - A load coinciding with a tick suppresses that En and restarts the prescaler.
  - A dir toggle coinciding with an En takes effect on the next En.
- Reset mid-operation: an in-progress debounce is abandoned, and a button still held at reset release must be re-qualified for DB_CYCLES cycles before it is accepted.

Decomposition:
- Package count_pkg:
  - CNT_W default constant.
  - Direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0.
  - Default DIV and DB_CYCLES values.
- Sub-module btn_debounce:
  - Parameter DB_CYCLES.
  - Ports clk, rst, raw, stable, press.
  - Instantiated three times.
- Prescaler, toggles and output registers stay in count_ctrl.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with all buttons active -> R=0, L=0, En=0, up_down=1, run=0 after the first edge, and all stay so while rst=1.
2. Load: sw_R=4'b1010, btn_load high for 12 cycles -> L=1 for exactly one cycle after edge 7 (DB_CYCLES=4), R=4'b1010 from that cycle on, En=0 throughout, no second L while the button is held.
3. Glitch: btn_load high for 3 cycles then low -> L never asserts and R is unchanged.
4. Run: press btn_run -> run=1 after edge 7, then En pulses one cycle wide with period 5 (DIV=5), first pulse 5 cycles after run rises. A second press -> run=0 and En stays 0.
5. Direction: while running, hold btn_dir for 20 cycles -> up_down goes 1->0 exactly once. Release and press again -> up_down returns to 1. En cadence is undisturbed.
6. Reset mid-run and load/tick collision: with run=1, time a load so press_load lands on presc=DIV-1 -> that En is suppressed, L=1, and the next En comes 5 cycles later. Then assert rst for 1 cycle -> run=0, up_down=1, En=0 from the next edge.
